fifo_rd_port: RTL and testbench
===============================

# fifo_rd_port

Read-side port of the FIFO, on the read clock domain, paired with the existing write side and dual-port memory. It keeps the binary/Gray read pointer and the registered empty flag, and drives the memory read address. It presents memory words to a consumer through a first-word-fall-through output register with a valid/ready handshake. The Gray write pointer arrives already synchronized into `rclk`, and this block publishes its own Gray read pointer for the write side's synchronizer.

## Interface
- `DATASIZE`, 8, memory word width
- `ADDRSIZE`, 4, memory address width; depth = 2^ADDRSIZE
- `AEMPTY_THRESH`, 2, almost-empty threshold in words (only with macro)

- `rclk`  in  1  read clock
- `rrst`  in  1  reset, synchronous and active-high
- `rq2_wptr`  in  ADDRSIZE+1  Gray write pointer, already synchronized to `rclk`
- `mem_rdata`  in  DATASIZE  combinational memory read data at `raddr`
- `raddr`  out  ADDRSIZE  memory read address = `rbin[ADDRSIZE-1:0]`
- `rptr`  out  ADDRSIZE+1  registered Gray read pointer
- `rempty`  out  1  registered; memory holds no unread word
- `rdata`  out  DATASIZE  output register
- `rvalid`  out  1  `rdata` holds a word
- `rready`  in  1  consumer accepts `rdata` this cycle
- `ralmost_empty`  out  1  only with macro

## Operation
- Internal pop: `rinc = !rempty && (!rvalid || rready)`.
- `rbinnext = rbin + rinc`, which wraps modulo 2^(ADDRSIZE+1).
- `rgraynext = rbinnext ^ (rbinnext >> 1)`.
- On every edge: `rbin <= rbinnext`, `rptr <= rgraynext`, `rempty <= (rgraynext == rq2_wptr)`.
- Output stage has two states:
  - **EMPTY** (`rvalid`=0): on `rinc`, `rdata <= mem_rdata`, `rvalid <= 1`, go to **HOLD**.
  - **HOLD** (`rvalid`=1): if `rready && rinc`, load the next word and stay (back-to-back). If `rready && !rinc`, set `rvalid <= 0` and go to **EMPTY**. If `!rready`, `rdata` and `rvalid` are frozen.
- `rdata` changes only on a load. It is never overwritten while `rvalid && !rready`.
- Memory empty with `rvalid`=1: the held word stays until accepted.
- Reset values: `rbin`=0, `rptr`=0, `rempty`=1, `rvalid`=0, `rdata`=0, `ralmost_empty`=1.
- Reset mid-operation drops any held word. The write side must be reset in the same window.

## Timing
- `mem_rdata` is sampled in the same cycle `raddr` is driven; memory read is combinational.
- Latency: a `rq2_wptr` change at edge N makes `rempty`=0 after edge N+1 and `rvalid`=1 after edge N+2.
- Throughput: one word per cycle while `rready`=1 and data is available.
- Handshake: transfer occurs when `rvalid && rready` at a rising edge. `rready` may depend combinationally on `rvalid`. `rvalid` has no combinational path from `rready`.
- Full-range wrap: after 2^(ADDRSIZE+1) pops, `rbin` returns to 0. Empty compare uses all ADDRSIZE+1 bits.

## Configuration
- Macro: `FIFO_RD_ALMOST_EMPTY_EN`.
- **Defined:**
  - `ralmost_empty` port exists.
  - Registered update: `ralmost_empty <= ((gray2bin(rq2_wptr) - rbinnext) mod 2^(ADDRSIZE+1)) <= AEMPTY_THRESH`.
  - Reset value is 1.
- **Undefined:** no port, no Gray-to-binary logic, `AEMPTY_THRESH` unused. All other behaviour is identical.

## Structure
- Package `fifo_pkg` holds:
  - default `DATASIZE`/`ADDRSIZE` constants;
  - functions `bin2gray` and `gray2bin`;
  - the output-stage state enum (EMPTY, HOLD).
- One sub-module, `rptr_empty`, owns `rbin`, `rptr`, `rempty` and the almost-empty logic. Its inputs are `rinc` and `rq2_wptr`.
- `fifo_rd_port` owns the output register, the FSM and `rinc`.

## Test plan
- **Reset:** assert `rrst` for 2 cycles with `rq2_wptr`=0 -> `rempty`=1, `rvalid`=0, `raddr`=0, `rptr`=0, `rdata`=0.
- **Single word:** model `mem[0]`=0xAA, step `rq2_wptr` 0 -> 1 at edge N -> `rempty`=0 after N+1; `rvalid`=1 and `rdata`=0xAA after N+2; `raddr`=1, `rptr`=1, `rempty`=1 after N+2.
- **Stream 16:** `mem[i]`=i and `rq2_wptr`=bin2gray(16), `rready`=1 -> `rdata` 0..15 on consecutive cycles; `rempty`=1 after the last pop; `rptr`=0x18.
- **Backpressure:** 3 words loaded, `rready`=0 for 5 cycles -> `rdata`=0 held, `rvalid`=1, `raddr`=1. Then `rready`=1 -> 1 then 2 on the next cycles.
- **Wrap:** 40 single-word write/read rounds -> `rbin` wraps past 31, and every word returns in order with no spurious `rvalid`.
- **Almost-empty (macro defined):** occupancy 3 -> `ralmost_empty`=0; pop 1 -> `ralmost_empty`=1 at the next edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants, pointer-encoding helpers and output-stage states for the FIFO read port.
package fifo_pkg;

  localparam int DATASIZE_DEF = 8;
  localparam int ADDRSIZE_DEF = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } ostate_e;

  // Both helpers work on a zero-extended 32-bit view; callers truncate to pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_port_rptr_empty.sv
// Read pointer (binary + Gray) and registered empty flag; almost-empty with FIFO_RD_ALMOST_EMPTY_EN.
module rptr_empty
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = ADDRSIZE_DEF
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  ,parameter int AEMPTY_THRESH = 2
`endif
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  ,output logic               ralmost_empty
`endif
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          rempty_q, rempty_d;

  always_comb begin
    rbin_d   = rbin_q + PW'(rinc);
    rptr_d   = PW'(bin2gray(32'(rbin_d)));
    // Full-width compare distinguishes empty from full after a wrap.
    rempty_d = (rptr_d == rq2_wptr);
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rempty_q <= rempty_d;
    end
  end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic [PW-1:0] wbin;
  logic          aempty_q, aempty_d;

  always_comb begin
    wbin     = PW'(gray2bin(32'(rq2_wptr)));
    aempty_d = ((wbin - rbin_d) <= PW'(AEMPTY_THRESH));
  end

  always_ff @(posedge rclk) begin
    if (rrst) aempty_q <= 1'b1;
    else      aempty_q <= aempty_d;
  end

  assign ralmost_empty = aempty_q;
`endif

  assign raddr  = rbin_q[ADDRSIZE-1:0];
  assign rptr   = rptr_q;
  assign rempty = rempty_q;

endmodule

// File: rtl/fifo_rd_port.sv
// FIFO read port: pointer/empty tracking plus a first-word-fall-through output register.
// Optional almost-empty output is enabled by defining FIFO_RD_ALMOST_EMPTY_EN.
module fifo_rd_port
  import fifo_pkg::*;
#(
  parameter int DATASIZE = DATASIZE_DEF,
  parameter int ADDRSIZE = ADDRSIZE_DEF
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  ,parameter int AEMPTY_THRESH = 2
`endif
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [DATASIZE-1:0] mem_rdata,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  input  logic                rready
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  ,output logic               ralmost_empty
`endif
);

  ostate_e             state_q, state_d;
  logic [DATASIZE-1:0] rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                rinc;

  // Pop only when the output register is free or being drained this cycle.
  assign rinc = !rempty && (!rvalid_q || rready);

  rptr_empty #(
    .ADDRSIZE      (ADDRSIZE)
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    ,.AEMPTY_THRESH(AEMPTY_THRESH)
`endif
  ) u_rptr_empty (
    .rclk          (rclk),
    .rrst          (rrst),
    .rinc          (rinc),
    .rq2_wptr      (rq2_wptr),
    .raddr         (raddr),
    .rptr          (rptr),
    .rempty        (rempty)
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    ,.ralmost_empty(ralmost_empty)
`endif
  );

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (rinc) begin
          rdata_d  = mem_rdata;
          rvalid_d = 1'b1;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (rready) begin
          if (rinc) begin
            rdata_d = mem_rdata;
          end else begin
            rvalid_d = 1'b0;
            state_d  = ST_EMPTY;
          end
        end
      end
      default: begin
        state_d  = ST_EMPTY;
        rvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q  <= ST_EMPTY;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_fifo_rd_port.sv
// Directed + randomized bench for fifo_rd_port against a pointer-count model and an in-order scoreboard.
module tb_fifo_rd_port;
  import fifo_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 1 << PW;
  localparam int THR   = 2;

  logic          rclk = 1'b0;
  logic          rrst;
  logic [PW-1:0] rq2_wptr;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] raddr;
  logic [PW-1:0] rptr;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rready;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic          ralmost_empty;
`endif

  logic [DW-1:0] mem [DEPTH];
  assign mem_rdata = mem[raddr];

  always #5 rclk = ~rclk;

  fifo_rd_port #(
    .DATASIZE      (DW),
    .ADDRSIZE      (AW)
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    ,.AEMPTY_THRESH(THR)
`endif
  ) dut (
    .rclk          (rclk),
    .rrst          (rrst),
    .rq2_wptr      (rq2_wptr),
    .mem_rdata     (mem_rdata),
    .raddr         (raddr),
    .rptr          (rptr),
    .rempty        (rempty),
    .rdata         (rdata),
    .rvalid        (rvalid),
    .rready        (rready)
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    ,.ralmost_empty(ralmost_empty)
`endif
  );

  int            n_cmp = 0;
  int            n_bad = 0;
  int            w_cnt;
  int            m_rd;
  bit            m_empty, m_valid, m_aempty;
  logic [DW-1:0] m_data;
  logic [DW-1:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    mem[w_cnt % DEPTH] = d;
    sb.push_back(d);
    w_cnt++;
    rq2_wptr = PW'(bin2gray(32'(w_cnt % PMOD)));
  endtask

  // One clock: the model advances from pre-edge inputs, then outputs are checked 1 time unit later.
  task automatic step();
    bit            rst_s, rdy_s, pop, v_s;
    int            w_s;
    logic [DW-1:0] d_s;
    rst_s = rrst; rdy_s = rready; w_s = w_cnt; v_s = rvalid; d_s = rdata;
    if (!rst_s && v_s && rdy_s) begin
      if (sb.size() == 0) chk("spurious_rvalid", 32'(v_s), 32'd0);
      else                chk("sb_order", 32'(d_s), 32'(sb.pop_front()));
    end
    @(posedge rclk);
    if (rst_s) begin
      m_rd = 0; m_empty = 1; m_valid = 0; m_data = '0; m_aempty = 1;
    end else begin
      pop = !m_empty && (!m_valid || rdy_s);
      if (m_valid && rdy_s) m_valid = 0;
      if (pop) begin
        m_data  = mem[m_rd % DEPTH];
        m_valid = 1;
        m_rd++;
      end
      m_empty  = ((m_rd % PMOD) == (w_s % PMOD));
      m_aempty = ((w_s - m_rd) <= THR);
    end
    #1;
    chk("rempty", 32'(rempty), 32'(m_empty));
    chk("rvalid", 32'(rvalid), 32'(m_valid));
    chk("rdata",  32'(rdata),  32'(m_data));
    chk("raddr",  32'(raddr),  32'(m_rd % DEPTH));
    chk("rptr",   32'(rptr),   bin2gray(32'(m_rd % PMOD)));
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    chk("ralmost_empty", 32'(ralmost_empty), 32'(m_aempty));
`endif
  endtask

  task automatic do_reset();
    rrst = 1'b1; rready = 1'b0; rq2_wptr = '0; w_cnt = 0;
    sb.delete();
    step(); step();
    rrst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rrst = 1'b1; rready = 1'b0; rq2_wptr = '0; w_cnt = 0;
    m_rd = 0; m_empty = 1; m_valid = 0; m_data = '0; m_aempty = 1;

    do_reset();
    chk("reset_rempty", 32'(rempty), 32'd1);
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_raddr",  32'(raddr),  32'd0);
    chk("reset_rptr",   32'(rptr),   32'd0);
    chk("reset_rdata",  32'(rdata),  32'd0);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    chk("reset_aempty", 32'(ralmost_empty), 32'd1);
`endif

    // Single word: empty clears one edge after the pointer moves, data one edge later.
    write_word(8'hAA);
    step();
    chk("single_rempty_n1", 32'(rempty), 32'd0);
    chk("single_rvalid_n1", 32'(rvalid), 32'd0);
    step();
    chk("single_rvalid_n2", 32'(rvalid), 32'd1);
    chk("single_rdata_n2",  32'(rdata),  32'hAA);
    chk("single_raddr_n2",  32'(raddr),  32'd1);
    chk("single_rptr_n2",   32'(rptr),   32'd1);
    chk("single_rempty_n2", 32'(rempty), 32'd1);
    rready = 1'b1;
    step();
    chk("single_drained", 32'(rvalid), 32'd0);

    // Stream a full memory at one word per cycle.
    do_reset();
    rready = 1'b1;
    for (int i = 0; i < DEPTH; i++) write_word(DW'(i));
    step();
    for (int i = 0; i < DEPTH; i++) begin
      step();
      chk("stream_data",  32'(rdata),  32'(i));
      chk("stream_valid", 32'(rvalid), 32'd1);
    end
    chk("stream_rempty", 32'(rempty), 32'd1);
    chk("stream_rptr",   32'(rptr),   32'h18);
    step();

    // Backpressure: held word must not change while the consumer stalls.
    do_reset();
    for (int i = 0; i < 3; i++) write_word(DW'(i));
    step(); step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_rdata",  32'(rdata),  32'd0);
      chk("bp_rvalid", 32'(rvalid), 32'd1);
      chk("bp_raddr",  32'(raddr),  32'd1);
    end
    rready = 1'b1;
    step();
    chk("bp_next1", 32'(rdata), 32'd1);
    step();
    chk("bp_next2", 32'(rdata), 32'd2);
    step();
    chk("bp_drained", 32'(rvalid), 32'd0);

`ifdef FIFO_RD_ALMOST_EMPTY_EN
    do_reset();
    for (int i = 0; i < 4; i++) write_word(DW'(8'h40 + i));
    step();
    step();
    chk("ae_occ3", 32'(ralmost_empty), 32'd0);
    rready = 1'b1;
    step();
    chk("ae_occ2", 32'(ralmost_empty), 32'd1);
    for (int i = 0; i < 6; i++) step();
`endif

    // Wrap: single-word rounds push the read pointer past the full binary range.
    rready = 1'b1;
    for (int r = 0; r < 40; r++) begin
      write_word(DW'($urandom));
      step(); step(); step();
    end
    chk("wrap_idle_rvalid", 32'(rvalid), 32'd0);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) != 0 && (w_cnt - m_rd) < DEPTH) write_word(DW'($urandom));
      rready = ($urandom_range(0, 3) != 0);
      step();
    end
    rready = 1'b1;
    for (int c = 0; c < 2 * DEPTH + 4; c++) step();
    chk("final_rvalid", 32'(rvalid), 32'd0);
    chk("final_rempty", 32'(rempty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
